cacheline_mem_adapter: RTL and testbench

Bridges the core's two line-granular clients (I-cache read-only, D-cache read/write) to the banked DRAM burst interface. It arbitrates between them and serialises 256-bit write lines into 4 × 64-bit beats. It deserialises returning read bursts, which may arrive out of order, and routes each completed line to its owner by returned address. It sits directly upstream of the banked memory model and downstream of the cache miss handlers.

---
 rtl/mem_adapter_pkg.sv | 32 +++
 rtl/line_assembler.sv | 69 ++++++
 rtl/cacheline_mem_adapter.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_cacheline_mem_adapter.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_adapter_pkg.sv
// ---------------------------------------------------------------------------
// mem_adapter_pkg
// Shared types and constants for the cache-line to DRAM-burst adapter.
//   BEAT_W    : width of one memory beat
//   BURST_LEN : beats per cache line
//   LINE_W    : cache line width
//   OFFSET_W  : byte-offset bits inside a line (forced to 0 toward memory)
//   client_e  : requesting client (I-cache / D-cache)
//   issue_state_e : issue-side FSM states
// ---------------------------------------------------------------------------
package mem_adapter_pkg;

    localparam int BEAT_W    = 64;
    localparam int BURST_LEN = 4;
    localparam int LINE_W    = BEAT_W * BURST_LEN;
    localparam int OFFSET_W  = 5;

    typedef enum logic {
        CL_IC = 1'b0,
        CL_DC = 1'b1
    } client_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WR0  = 3'd2,
        WR1  = 3'd3,
        WR2  = 3'd4,
        WR3  = 3'd5
    } issue_state_e;

endpackage

// File: rtl/line_assembler.sv
// ---------------------------------------------------------------------------
// line_assembler
// Collects read-return beats into a full cache line.
//   clk, rst         : clock, async active-low reset
//   i_rvalid         : return beat valid
//   i_raddr          : return address (captured on beat 0)
//   i_rdata          : return beat data
//   o_line           : assembled line, stable while o_line_valid is high
//   o_line_addr      : address captured with beat 0
//   o_line_valid     : 1-cycle pulse, the cycle after the last beat
//   o_abort          : rvalid dropped mid-burst (partial line discarded)
// ---------------------------------------------------------------------------
module line_assembler #(
    parameter int ADDR_W    = 32,
    parameter int BEAT_W    = mem_adapter_pkg::BEAT_W,
    parameter int BURST_LEN = mem_adapter_pkg::BURST_LEN,
    parameter int LINE_W    = BEAT_W * BURST_LEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_rvalid,
    input  logic [ADDR_W-1:0] i_raddr,
    input  logic [BEAT_W-1:0] i_rdata,
    output logic [LINE_W-1:0] o_line,
    output logic [ADDR_W-1:0] o_line_addr,
    output logic              o_line_valid,
    output logic              o_abort
);

    localparam int CNT_W = $clog2(BURST_LEN);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    logic [CNT_W-1:0]  r_cnt;
    logic [LINE_W-1:0] r_line;
    logic [ADDR_W-1:0] r_addr;
    logic              r_line_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt        <= '0;
            r_line       <= '0;
            r_addr       <= '0;
            r_line_valid <= 1'b0;
        end else begin
            r_line_valid <= 1'b0;
            if (i_rvalid) begin
                r_line[int'(r_cnt)*BEAT_W +: BEAT_W] <= i_rdata;
                if (r_cnt == '0) begin
                    r_addr <= i_raddr;
                end
                if (r_cnt == LAST_BEAT) begin
                    r_cnt        <= '0;
                    r_line_valid <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else if (r_cnt != '0) begin
                // Gap inside a burst: restart; stale beats get overwritten.
                r_cnt <= '0;
            end
        end
    end

    assign o_abort      = ~i_rvalid & (r_cnt != '0);
    assign o_line       = r_line;
    assign o_line_addr  = r_addr;
    assign o_line_valid = r_line_valid;

endmodule

// File: rtl/cacheline_mem_adapter.sv
// ---------------------------------------------------------------------------
// cacheline_mem_adapter
// Bridges I-cache (read) and D-cache (read/write) line requests onto a
// beat-wide DRAM burst interface; routes returned lines by address.
//   clk, rst                         : clock, async active-low reset
//   ic_addr, ic_read                 : I-cache line read request (held)
//   ic_rdata, ic_resp                : I-cache line return (1-cycle pulse)
//   dc_addr, dc_read, dc_write,
//   dc_wdata                         : D-cache request (held)
//   dc_rdata, dc_resp                : D-cache return / write done (pulse)
//   bmem_addr, bmem_read, bmem_write,
//   bmem_wdata, bmem_ready           : request / write beats to memory
//   bmem_raddr, bmem_rdata,
//   bmem_rvalid                      : read return beats
//   err                              : sticky protocol error
//
// Issue FSM:
//   state | meaning
//   IDLE  | arbitrate between waiting clients
//   RD    | read request on bus until bmem_ready
//   WR0-3 | write beat k on bus until bmem_ready
// ---------------------------------------------------------------------------
module cacheline_mem_adapter #(
    parameter int ADDR_W    = 32,
    parameter int BEAT_W    = 64,
    parameter int BURST_LEN = 4,
    parameter int LINE_W    = BEAT_W * BURST_LEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ic_addr,
    input  logic              ic_read,
    output logic [LINE_W-1:0] ic_rdata,
    output logic              ic_resp,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic              dc_read,
    input  logic              dc_write,
    input  logic [LINE_W-1:0] dc_wdata,
    output logic [LINE_W-1:0] dc_rdata,
    output logic              dc_resp,
    output logic [ADDR_W-1:0] bmem_addr,
    output logic              bmem_read,
    output logic              bmem_write,
    output logic [BEAT_W-1:0] bmem_wdata,
    input  logic              bmem_ready,
    input  logic [ADDR_W-1:0] bmem_raddr,
    input  logic [BEAT_W-1:0] bmem_rdata,
    input  logic              bmem_rvalid,
    output logic              err
);

    import mem_adapter_pkg::*;

    // Client latches: pend = outstanding, wait = latched but not yet issued.
    logic                     r_ic_pend;
    logic                     r_ic_wait;
    logic [ADDR_W-1:OFFSET_W] r_ic_addr;
    logic                     r_dc_pend;
    logic                     r_dc_wait;
    logic                     r_dc_write;
    logic [ADDR_W-1:OFFSET_W] r_dc_addr;

    issue_state_e             r_state;
    issue_state_e             w_next_state;
    client_e                  r_last_grant;
    logic [ADDR_W-1:0]        r_issue_addr;

    logic                     r_ic_resp;
    logic [LINE_W-1:0]        r_ic_rdata;
    logic                     r_dc_resp;
    logic [LINE_W-1:0]        r_dc_rdata;
    logic                     r_err;

    logic                     w_ic_new;
    logic                     w_dc_new;
    logic                     w_grant_ic;
    logic                     w_grant_dc;
    logic                     w_wr_done;
    logic [LINE_W-1:0]        w_line;
    logic [ADDR_W-1:0]        w_line_addr;
    logic                     w_line_valid;
    logic                     w_abort;
    logic                     w_match_ic;
    logic                     w_match_dc;
    logic                     w_unused_offset_bits;

    assign w_ic_new = ic_read & ~r_ic_pend;
    assign w_dc_new = (dc_read | dc_write) & ~r_dc_pend;

    // -----------------------------------------------------------------------
    // Return path
    // -----------------------------------------------------------------------
    line_assembler #(
        .ADDR_W    (ADDR_W),
        .BEAT_W    (BEAT_W),
        .BURST_LEN (BURST_LEN),
        .LINE_W    (LINE_W)
    ) u_line_assembler (
        .clk          (clk),
        .rst          (rst),
        .i_rvalid     (bmem_rvalid),
        .i_raddr      (bmem_raddr),
        .i_rdata      (bmem_rdata),
        .o_line       (w_line),
        .o_line_addr  (w_line_addr),
        .o_line_valid (w_line_valid),
        .o_abort      (w_abort)
    );

    // Both clients may match the same line; each match gets its own resp.
    assign w_match_ic = w_line_valid & r_ic_pend
                      & (r_ic_addr == w_line_addr[ADDR_W-1:OFFSET_W]);
    assign w_match_dc = w_line_valid & r_dc_pend & ~r_dc_write
                      & (r_dc_addr == w_line_addr[ADDR_W-1:OFFSET_W]);

    assign w_unused_offset_bits = ^{ic_addr[OFFSET_W-1:0],
                                    dc_addr[OFFSET_W-1:0],
                                    w_line_addr[OFFSET_W-1:0]};

    // -----------------------------------------------------------------------
    // Request latches. The resp pulse clears pend on its closing edge, which
    // blocks a still-held request from re-latching during its own resp cycle.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ic_pend <= 1'b0;
            r_ic_wait <= 1'b0;
            r_ic_addr <= '0;
        end else if (r_ic_resp) begin
            r_ic_pend <= 1'b0;
            r_ic_wait <= 1'b0;
        end else if (w_ic_new) begin
            r_ic_pend <= 1'b1;
            r_ic_wait <= 1'b1;
            r_ic_addr <= ic_addr[ADDR_W-1:OFFSET_W];
        end else if (w_grant_ic) begin
            r_ic_wait <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dc_pend  <= 1'b0;
            r_dc_wait  <= 1'b0;
            r_dc_write <= 1'b0;
            r_dc_addr  <= '0;
        end else if (r_dc_resp) begin
            r_dc_pend <= 1'b0;
            r_dc_wait <= 1'b0;
        end else if (w_dc_new) begin
            r_dc_pend  <= 1'b1;
            r_dc_wait  <= 1'b1;
            r_dc_write <= dc_write;
            r_dc_addr  <= dc_addr[ADDR_W-1:OFFSET_W];
        end else if (w_grant_dc) begin
            r_dc_wait <= 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Round-robin arbiter, evaluated only while the FSM is idle.
    // -----------------------------------------------------------------------
    always_comb begin
        w_grant_ic = 1'b0;
        w_grant_dc = 1'b0;
        if (r_state == IDLE) begin
            if (r_ic_wait && r_dc_wait) begin
                if (r_last_grant == CL_IC) begin
                    w_grant_dc = 1'b1;
                end else begin
                    w_grant_ic = 1'b1;
                end
            end else begin
                w_grant_ic = r_ic_wait;
                w_grant_dc = r_dc_wait;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_grant <= CL_DC;
            r_issue_addr <= '0;
        end else if (w_grant_ic) begin
            r_last_grant <= CL_IC;
            r_issue_addr <= {r_ic_addr, {OFFSET_W{1'b0}}};
        end else if (w_grant_dc) begin
            r_last_grant <= CL_DC;
            r_issue_addr <= {r_dc_addr, {OFFSET_W{1'b0}}};
        end
    end

    // -----------------------------------------------------------------------
    // Issue FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant_ic) begin
                    w_next_state = RD;
                end else if (w_grant_dc) begin
                    w_next_state = r_dc_write ? WR0 : RD;
                end
            end
            RD:      if (bmem_ready) w_next_state = IDLE;
            WR0:     if (bmem_ready) w_next_state = WR1;
            WR1:     if (bmem_ready) w_next_state = WR2;
            WR2:     if (bmem_ready) w_next_state = WR3;
            WR3:     if (bmem_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        bmem_read  = 1'b0;
        bmem_write = 1'b0;
        bmem_addr  = '0;
        bmem_wdata = '0;
        case (r_state)
            RD: begin
                bmem_read = 1'b1;
                bmem_addr = r_issue_addr;
            end
            WR0: begin
                bmem_write = 1'b1;
                bmem_addr  = r_issue_addr;
                bmem_wdata = dc_wdata[0*BEAT_W +: BEAT_W];
            end
            WR1: begin
                bmem_write = 1'b1;
                bmem_addr  = r_issue_addr;
                bmem_wdata = dc_wdata[1*BEAT_W +: BEAT_W];
            end
            WR2: begin
                bmem_write = 1'b1;
                bmem_addr  = r_issue_addr;
                bmem_wdata = dc_wdata[2*BEAT_W +: BEAT_W];
            end
            WR3: begin
                bmem_write = 1'b1;
                bmem_addr  = r_issue_addr;
                bmem_wdata = dc_wdata[3*BEAT_W +: BEAT_W];
            end
            default: ;
        endcase
    end

    // Writes are posted: done as soon as the last beat is accepted.
    assign w_wr_done = (r_state == WR3) & bmem_ready;

    // -----------------------------------------------------------------------
    // Responses and error flag
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ic_resp  <= 1'b0;
            r_ic_rdata <= '0;
            r_dc_resp  <= 1'b0;
            r_dc_rdata <= '0;
            r_err      <= 1'b0;
        end else begin
            r_ic_resp <= w_match_ic;
            r_dc_resp <= w_match_dc | w_wr_done;
            if (w_match_ic) begin
                r_ic_rdata <= w_line;
            end
            if (w_match_dc) begin
                r_dc_rdata <= w_line;
            end
            if ((w_dc_new & dc_read & dc_write)
                || (w_line_valid & ~w_match_ic & ~w_match_dc)
                || w_abort) begin
                r_err <= 1'b1;
            end
        end
    end

    assign ic_resp  = r_ic_resp;
    assign ic_rdata = r_ic_rdata;
    assign dc_resp  = r_dc_resp;
    assign dc_rdata = r_dc_rdata;
    assign err      = r_err;

endmodule

// File: tb/tb_cacheline_mem_adapter.sv
module tb_cacheline_mem_adapter;

    localparam int ADDR_W = 32;
    localparam int BEAT_W = 64;
    localparam int LINE_W = 256;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] ic_addr;
    logic              ic_read;
    logic [LINE_W-1:0] ic_rdata;
    logic              ic_resp;
    logic [ADDR_W-1:0] dc_addr;
    logic              dc_read;
    logic              dc_write;
    logic [LINE_W-1:0] dc_wdata;
    logic [LINE_W-1:0] dc_rdata;
    logic              dc_resp;
    logic [ADDR_W-1:0] bmem_addr;
    logic              bmem_read;
    logic              bmem_write;
    logic [BEAT_W-1:0] bmem_wdata;
    logic              bmem_ready;
    logic [ADDR_W-1:0] bmem_raddr;
    logic [BEAT_W-1:0] bmem_rdata;
    logic              bmem_rvalid;
    logic              err;

    int n_tests = 0;
    int n_fail  = 0;

    // Scoreboards: pushed when stimulus is driven, popped at DUT output.
    logic [LINE_W-1:0] ic_q[$];
    logic [LINE_W-1:0] dc_q[$];
    logic [ADDR_W-1:0] iss_q[$];
    logic [BEAT_W-1:0] beat_q[$];
    bit                tb_last_dc;

    always #5 clk = ~clk;

    cacheline_mem_adapter dut (
        .clk         (clk),
        .rst         (rst),
        .ic_addr     (ic_addr),
        .ic_read     (ic_read),
        .ic_rdata    (ic_rdata),
        .ic_resp     (ic_resp),
        .dc_addr     (dc_addr),
        .dc_read     (dc_read),
        .dc_write    (dc_write),
        .dc_wdata    (dc_wdata),
        .dc_rdata    (dc_rdata),
        .dc_resp     (dc_resp),
        .bmem_addr   (bmem_addr),
        .bmem_read   (bmem_read),
        .bmem_write  (bmem_write),
        .bmem_wdata  (bmem_wdata),
        .bmem_ready  (bmem_ready),
        .bmem_raddr  (bmem_raddr),
        .bmem_rdata  (bmem_rdata),
        .bmem_rvalid (bmem_rvalid),
        .err         (err)
    );

    function automatic logic [LINE_W-1:0] mk_line(input logic [31:0] seed);
        logic [LINE_W-1:0] l;
        l = '0;
        for (int k = 0; k < 4; k++) begin
            l[k*BEAT_W +: BEAT_W] = {seed ^ 32'hC0DE_0000, 32'h1111_1111 * 32'(k + 1)};
        end
        return l;
    endfunction

    // Waits (bounded) for a read request on the bus; ready is held high.
    task automatic wait_read(output logic [ADDR_W-1:0] a, output int cyc, output bit ok);
        a = '0; cyc = 0; ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cyc++;
            if (bmem_read) begin
                a  = bmem_addr;
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Four beats then rvalid low; returns on the negedge after beat 3's edge.
    task automatic send_burst(input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] line);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bmem_rvalid = 1'b1;
            bmem_raddr  = a;
            bmem_rdata  = line[k*BEAT_W +: BEAT_W];
        end
        @(negedge clk);
        bmem_rvalid = 1'b0;
        bmem_raddr  = '0;
        bmem_rdata  = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({ic_resp, dc_resp, bmem_read, bmem_write, err} !== 5'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b want 00000", {ic_resp, dc_resp, bmem_read, bmem_write, err});
        end
        n_tests++;
        if (bmem_addr !== '0 || bmem_wdata !== '0) begin
            n_fail++; $display("FAIL reset_bus: addr %h wdata %h want 0", bmem_addr, bmem_wdata);
        end
        n_tests++;
        if (ic_rdata !== '0 || dc_rdata !== '0) begin
            n_fail++; $display("FAIL reset_rdata: ic %h dc %h want 0", ic_rdata, dc_rdata);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ic_read();
        logic [BEAT_W-1:0] a_b, b_b, c_b, d_b;
        logic [LINE_W-1:0] line, exp;
        logic [ADDR_W-1:0] a, ea;
        int cyc; bit ok;
        a_b = 64'hAAAA_0000_0000_000A; b_b = 64'hBBBB_0000_0000_000B;
        c_b = 64'hCCCC_0000_0000_000C; d_b = 64'hDDDD_0000_0000_000D;
        line = {d_b, c_b, b_b, a_b};
        ic_q.push_back(line);
        iss_q.push_back(32'h0000_1000);
        @(negedge clk);
        ic_addr = 32'h0000_1000; ic_read = 1'b1;
        wait_read(a, cyc, ok);
        tb_last_dc = 1'b0;
        ea = iss_q.pop_front();
        n_tests++;
        if (!ok || cyc != 2) begin
            n_fail++; $display("FAIL ic_rd_latency: got %0d cycles (seen=%0d) want 2", cyc, ok);
        end
        n_tests++;
        if (a !== ea) begin
            n_fail++; $display("FAIL ic_rd_addr: got %h want %h", a, ea);
        end
        @(negedge clk);
        n_tests++;
        if (bmem_read !== 1'b0) begin
            n_fail++; $display("FAIL ic_rd_release: bmem_read %b want 0", bmem_read);
        end
        send_burst(32'h0000_1000, line);
        n_tests++;
        if (ic_resp !== 1'b0) begin
            n_fail++; $display("FAIL ic_resp_early: got %b want 0", ic_resp);
        end
        @(negedge clk);
        exp = ic_q.pop_front();
        n_tests++;
        if (ic_resp !== 1'b1 || ic_rdata !== exp) begin
            n_fail++; $display("FAIL ic_resp_line: resp %b data %h want 1 %h", ic_resp, ic_rdata, exp);
        end
        ic_read = 1'b0;
        @(negedge clk);
        n_tests++;
        if (ic_resp !== 1'b0 || ic_rdata !== exp) begin
            n_fail++; $display("FAIL ic_resp_pulse_hold: resp %b data %h want 0 %h", ic_resp, ic_rdata, exp);
        end
    endtask

    task automatic test_dc_write();
        logic [LINE_W-1:0] w;
        logic [BEAT_W-1:0] exp;
        int n_acc, stall; bit done;
        w = mk_line(32'h0000_2000);
        for (int k = 0; k < 4; k++) beat_q.push_back(w[k*BEAT_W +: BEAT_W]);
        @(negedge clk);
        dc_addr = 32'h0000_2000; dc_wdata = w; dc_write = 1'b1;
        n_acc = 0; stall = 0; done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (bmem_write) begin
                if (n_acc == 2 && stall < 2) begin
                    bmem_ready = 1'b0;
                    stall++;
                    n_tests++;
                    if (bmem_wdata !== w[2*BEAT_W +: BEAT_W]) begin
                        n_fail++; $display("FAIL wr_hold: got %h want %h", bmem_wdata, w[2*BEAT_W +: BEAT_W]);
                    end
                end else if (beat_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL wr_extra_beat: got %h want none", bmem_wdata);
                    done = 1'b1;
                end else begin
                    bmem_ready = 1'b1;
                    exp = beat_q.pop_front();
                    n_tests++;
                    if (bmem_wdata !== exp || bmem_addr !== 32'h0000_2000) begin
                        n_fail++; $display("FAIL wr_beat%0d: got %h @%h want %h @00002000", n_acc, bmem_wdata, bmem_addr, exp);
                    end
                    n_acc++;
                end
            end else if (n_acc == 4) begin
                done = 1'b1;
                n_tests++;
                if (dc_resp !== 1'b1) begin
                    n_fail++; $display("FAIL wr_resp: got %b want 1", dc_resp);
                end
            end
        end
        bmem_ready = 1'b1;
        tb_last_dc = 1'b1;
        n_tests++;
        if (!done || n_acc != 4) begin
            n_fail++; $display("FAIL wr_timeout: accepted %0d beats want 4", n_acc);
        end
        dc_write = 1'b0;
        @(negedge clk);
        n_tests++;
        if (dc_resp !== 1'b0 || err !== 1'b0) begin
            n_fail++; $display("FAIL wr_after: resp %b err %b want 0 0", dc_resp, err);
        end
    endtask

    task automatic test_dual_read(input logic [ADDR_W-1:0] ia, input logic [ADDR_W-1:0] da);
        logic [LINE_W-1:0] li, ld, exp;
        logic [ADDR_W-1:0] a, ea;
        int cyc; bit ok;
        li = mk_line(ia); ld = mk_line(da);
        ic_q.push_back(li); dc_q.push_back(ld);
        if (tb_last_dc) begin
            iss_q.push_back(ia); iss_q.push_back(da);
        end else begin
            iss_q.push_back(da); iss_q.push_back(ia);
        end
        tb_last_dc = ~tb_last_dc;
        @(negedge clk);
        ic_addr = ia; ic_read = 1'b1;
        dc_addr = da; dc_read = 1'b1;
        for (int n = 0; n < 2; n++) begin
            wait_read(a, cyc, ok);
            ea = iss_q.pop_front();
            n_tests++;
            if (!ok || a !== ea) begin
                n_fail++; $display("FAIL dual_issue%0d: got %h (seen=%0d) want %h", n, a, ok, ea);
            end
        end
        send_burst(da, ld);
        @(negedge clk);
        exp = dc_q.pop_front();
        n_tests++;
        if (dc_resp !== 1'b1 || ic_resp !== 1'b0 || dc_rdata !== exp) begin
            n_fail++; $display("FAIL dual_dc_first: dc %b ic %b data %h want 1 0 %h", dc_resp, ic_resp, dc_rdata, exp);
        end
        dc_read = 1'b0;
        send_burst(ia, li);
        @(negedge clk);
        exp = ic_q.pop_front();
        n_tests++;
        if (ic_resp !== 1'b1 || dc_resp !== 1'b0 || ic_rdata !== exp) begin
            n_fail++; $display("FAIL dual_ic_second: ic %b dc %b data %h want 1 0 %h", ic_resp, dc_resp, ic_rdata, exp);
        end
        ic_read = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [LINE_W-1:0] l7, l8, exp;
        logic [ADDR_W-1:0] a, ea;
        int cyc; bit ok;
        l7 = mk_line(32'h0000_7000); l8 = mk_line(32'h0000_8000);
        ic_q.push_back(l7); iss_q.push_back(32'h0000_7000);
        @(negedge clk);
        ic_addr = 32'h0000_7013; ic_read = 1'b1;
        wait_read(a, cyc, ok);
        tb_last_dc = 1'b0;
        ea = iss_q.pop_front();
        n_tests++;
        if (!ok || a !== ea) begin
            n_fail++; $display("FAIL b2b_offset_mask: got %h want %h", a, ea);
        end
        send_burst(32'h0000_7000, l7);
        @(negedge clk);
        exp = ic_q.pop_front();
        n_tests++;
        if (ic_resp !== 1'b1 || ic_rdata !== exp) begin
            n_fail++; $display("FAIL b2b_first_resp: resp %b data %h want 1 %h", ic_resp, ic_rdata, exp);
        end
        // New request held through the resp cycle: latched one cycle later.
        ic_addr = 32'h0000_8000;
        ic_q.push_back(l8); iss_q.push_back(32'h0000_8000);
        wait_read(a, cyc, ok);
        ea = iss_q.pop_front();
        n_tests++;
        if (!ok || cyc != 3 || a !== ea) begin
            n_fail++; $display("FAIL b2b_relatch: got %h after %0d cycles want %h after 3", a, cyc, ea);
        end
        send_burst(32'h0000_8000, l8);
        @(negedge clk);
        exp = ic_q.pop_front();
        n_tests++;
        if (ic_resp !== 1'b1 || ic_rdata !== exp) begin
            n_fail++; $display("FAIL b2b_second_resp: resp %b data %h want 1 %h", ic_resp, ic_rdata, exp);
        end
        ic_read = 1'b0;
    endtask

    task automatic test_same_addr();
        logic [LINE_W-1:0] l5, ei, ed;
        logic [ADDR_W-1:0] a, ea;
        int cyc; bit ok;
        l5 = mk_line(32'h0000_5000);
        ic_q.push_back(l5); dc_q.push_back(l5);
        iss_q.push_back(32'h0000_5000); iss_q.push_back(32'h0000_5000);
        @(negedge clk);
        ic_addr = 32'h0000_5000; ic_read = 1'b1;
        dc_addr = 32'h0000_5000; dc_read = 1'b1;
        for (int n = 0; n < 2; n++) begin
            wait_read(a, cyc, ok);
            ea = iss_q.pop_front();
            n_tests++;
            if (!ok || a !== ea) begin
                n_fail++; $display("FAIL same_issue%0d: got %h (seen=%0d) want %h", n, a, ok, ea);
            end
        end
        send_burst(32'h0000_5000, l5);
        @(negedge clk);
        ei = ic_q.pop_front(); ed = dc_q.pop_front();
        n_tests++;
        if (ic_resp !== 1'b1 || dc_resp !== 1'b1) begin
            n_fail++; $display("FAIL same_resp: ic %b dc %b want 1 1", ic_resp, dc_resp);
        end
        n_tests++;
        if (ic_rdata !== ei || dc_rdata !== ed) begin
            n_fail++; $display("FAIL same_data: ic %h dc %h want %h", ic_rdata, dc_rdata, ei);
        end
        ic_read = 1'b0; dc_read = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_no_match();
        int resp_seen;
        n_tests++;
        if (err !== 1'b0) begin
            n_fail++; $display("FAIL nomatch_err_before: got %b want 0", err);
        end
        send_burst(32'h0000_9000, mk_line(32'h0000_9000));
        resp_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (ic_resp || dc_resp) resp_seen++;
        end
        n_tests++;
        if (resp_seen != 0 || err !== 1'b1) begin
            n_fail++; $display("FAIL nomatch: resp pulses %0d err %b want 0 1", resp_seen, err);
        end
        repeat (5) @(negedge clk);
        n_tests++;
        if (err !== 1'b1) begin
            n_fail++; $display("FAIL err_sticky: got %b want 1", err);
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [LINE_W-1:0] la, lb, exp;
        logic [ADDR_W-1:0] a, ea;
        int cyc; bit ok;
        la = mk_line(32'h0000_A000); lb = mk_line(32'h0000_B000);
        @(negedge clk);
        ic_addr = 32'h0000_A000; ic_read = 1'b1;
        wait_read(a, cyc, ok);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bmem_rvalid = 1'b1; bmem_raddr = 32'h0000_A000;
            bmem_rdata = la[k*BEAT_W +: BEAT_W];
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if ({ic_resp, dc_resp, bmem_read, bmem_write, err} !== 5'b0 || ic_rdata !== '0) begin
            n_fail++; $display("FAIL rst_async: flags %b ic_rdata %h want 00000 0", {ic_resp, dc_resp, bmem_read, bmem_write, err}, ic_rdata);
        end
        @(negedge clk);
        bmem_rvalid = 1'b0; ic_read = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        ic_q.push_back(lb); iss_q.push_back(32'h0000_B000);
        ic_addr = 32'h0000_B000; ic_read = 1'b1;
        wait_read(a, cyc, ok);
        ea = iss_q.pop_front();
        n_tests++;
        if (!ok || cyc != 2 || a !== ea) begin
            n_fail++; $display("FAIL post_rst_issue: got %h after %0d want %h after 2", a, cyc, ea);
        end
        send_burst(32'h0000_B000, lb);
        @(negedge clk);
        exp = ic_q.pop_front();
        n_tests++;
        if (ic_resp !== 1'b1 || ic_rdata !== exp || err !== 1'b0) begin
            n_fail++; $display("FAIL post_rst_resp: resp %b err %b data %h want 1 0 %h", ic_resp, err, ic_rdata, exp);
        end
        ic_read = 1'b0;
        // Burst that stops after two beats.
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            bmem_rvalid = 1'b1; bmem_raddr = 32'h0000_C000;
            bmem_rdata = lb[k*BEAT_W +: BEAT_W];
        end
        @(negedge clk);
        bmem_rvalid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (err !== 1'b1 || ic_resp !== 1'b0) begin
            n_fail++; $display("FAIL abort_err: err %b resp %b want 1 0", err, ic_resp);
        end
    endtask

    initial begin
        rst = 1'b0;
        ic_addr = '0; ic_read = 1'b0;
        dc_addr = '0; dc_read = 1'b0; dc_write = 1'b0; dc_wdata = '0;
        bmem_ready = 1'b1; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 1'b0;
        tb_last_dc = 1'b1;
        test_reset();
        test_ic_read();
        test_dc_write();
        test_dual_read(32'h0000_3000, 32'h0000_4000);
        test_back_to_back();
        test_dual_read(32'h0000_3100, 32'h0000_4100);
        test_same_addr();
        test_no_match();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
